wrr_grant_scheduler: RTL
========================

Name: wrr_grant_scheduler

Overview:
- Packet-level scheduler granting the shared SRAM write path to one of num_of_ports ingress ports.
- Selects in strict-priority (SP) or weighted-round-robin (WRR) mode and holds the grant from decision until the granted port's eop.
- Keeps per-port WRR credit counters and a rotating pointer, so arbitration is fair across packets, not just per cycle.
- Drives the write-path mux select and transfer-active flag.

Parameters:
- num_of_ports, 16, number of requesting ports (2..16).
- TIMEOUT_CYCLES, 1024, cycle budget per transfer; used only with ARB_TIMEOUT_EN.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- sp0_wrr1  input  1  mode: 0 = strict priority, 1 = WRR; sampled only at a decision.
- req  input  num_of_ports  level; port i holds a complete packet ready to write.
- eop  input  num_of_ports  single-cycle pulse; last word of the current packet.
- priority_in  input  num_of_ports*3  3-bit priority per port; port i uses bits [3i+2:3i]; 7 = highest.
- grant  output  num_of_ports  one-hot grant; all zero when idle.
- select  output  4  index of the granted port; 0 when idle.
- transfering  output  1  high while a grant is held.
- timeout_err  output  1  one-cycle pulse on forced release; tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, state IDLE, rr_ptr = num_of_ports-1, all credits = 0.
- State IDLE:
  - If |req = 1 in cycle t, a winner is computed combinationally.
  - Registered outputs update at t+1: grant one-hot, select, transfering=1. State goes to XFER.
- State XFER:
  - Hold grant and select. req changes and other ports' eop are ignored.
  - eop[select]=1 in cycle t -> at t+1 grant=0, select=0, transfering=0, state IDLE.
  - Next grant is earliest at t+2, so there is a mandatory 1-cycle gap.
- Scan order: circular, starting at rr_ptr+1 and wrapping from num_of_ports-1 to 0. On every grant, rr_ptr <= winner.
- SP mode:
  - Winner = requesting port with the highest priority_in.
  - Ties are resolved by scan order, so equal-priority ports rotate.
  - Credits are not modified.
- WRR mode:
  - Eligible = req[i] && credit[i] != 0. Winner = first eligible port in scan order.
  - On grant, credit[winner] decrements by 1.
  - If no eligible port exists but |req = 1: in the same cycle, reload every credit[i] = priority_in[i] + 1 (range 1..8, 4-bit counter). Then pick the first requesting port in scan order, and that port's credit stores the reloaded value minus 1.
  - Priority changes take effect at the next reload only.
- Credits persist across mode switches. A switch during XFER affects the next decision only.
- req deasserted on a port does not clear its credit.
- Simultaneous events:
  - eop[select] in the same cycle as new req: release wins; the new req is served per the gap rule.
  - An eop pulse in the grant cycle itself (t+1) counts and ends the transfer.
- Reset mid-transfer drops the grant immediately (asynchronously). No partial state survives.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entering XFER and increments each XFER cycle.
  - When it reaches TIMEOUT_CYCLES without eop[select], the next cycle forces release exactly like an eop and pulses timeout_err for 1 cycle.
  - The counter clears on release.
- Undefined: no counter; timeout_err is constant 0; the grant is held indefinitely until eop.

Test Plan:
- Reset/idle: rst=0 then 1, req=0 -> grant=0, select=0, transfering=0; async assert during XFER clears outputs without a clock edge.
- SP priority: sp0_wrr1=0, req=16'h0024, prio[2]=3, prio[5]=6 -> select=5 one cycle after req. After eop[5] -> transfering=0 for 1 cycle, then select=2.
- SP tie rotation: req=16'h0011, prio[0]=prio[4]=4, eop each packet -> grant sequence 0,4,0,4.
- WRR weights: sp0_wrr1=1, req=16'h0003 held, prio[0]=2, prio[1]=0, eop per packet -> first 4 grants are 0,1,0,0, then reload; over 8 packets port0:port1 = 6:2.
- eop filtering: grant to port 3, pulse eop[7] -> grant held; eop[3] -> released next cycle.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8: grant with no eop -> after 8 XFER cycles, transfering falls and timeout_err pulses high for exactly 1 cycle.

Source files
------------

// File: rtl/wrr_grant_scheduler.sv
// Packet-level SP/WRR arbiter for the shared SRAM write path; grant is held until the winner's eop.
// Optional ARB_TIMEOUT_EN macro adds a per-transfer cycle budget with forced release and timeout_err pulse.
module wrr_grant_scheduler #(
  parameter int num_of_ports   = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sp0_wrr1,
  input  logic [num_of_ports-1:0]   req,
  input  logic [num_of_ports-1:0]   eop,
  input  logic [num_of_ports*3-1:0] priority_in,
  output logic [num_of_ports-1:0]   grant,
  output logic [3:0]                select,
  output logic                      transfering,
  output logic                      timeout_err
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  logic [0:0]              state_reg;
  logic [num_of_ports-1:0] grant_reg;
  logic [3:0]              select_reg;
  logic                    transfering_reg;
  logic [3:0]              rr_ptr_reg;
  logic [3:0]              credit_reg [num_of_ports];
  logic [2:0]              prio_arr   [num_of_ports];

  logic       sp_found, wrr_found, req_found;
  logic [3:0] sp_idx, wrr_idx, req_idx, winner_idx;
  logic [2:0] sp_best;
  logic       decide, reload, release_now, timeout_hit;

  genvar gi;
  generate
    for (gi = 0; gi < num_of_ports; gi++) begin : g_prio
      assign prio_arr[gi] = priority_in[3*gi +: 3];
    end
  endgenerate

  // One circular pass from rr_ptr+1 gathers the SP, WRR and first-requester candidates.
  always_comb begin
    sp_found  = 1'b0;
    wrr_found = 1'b0;
    req_found = 1'b0;
    sp_idx    = 4'd0;
    wrr_idx   = 4'd0;
    req_idx   = 4'd0;
    sp_best   = 3'd0;
    for (int k = 0; k < num_of_ports; k++) begin
      int         s;
      logic [3:0] idx;
      s = int'(rr_ptr_reg) + 1 + k;
      if (s >= num_of_ports) s = s - num_of_ports;
      idx = 4'(s);
      if (req[idx]) begin
        if (!req_found) begin
          req_found = 1'b1;
          req_idx   = idx;
        end
        // Strict greater-than keeps the earliest port in scan order on ties.
        if (!sp_found || prio_arr[idx] > sp_best) begin
          sp_found = 1'b1;
          sp_idx   = idx;
          sp_best  = prio_arr[idx];
        end
        if (!wrr_found && credit_reg[idx] != 4'd0) begin
          wrr_found = 1'b1;
          wrr_idx   = idx;
        end
      end
    end
  end

  assign decide     = (state_reg == IDLE) && (|req);
  assign reload     = sp0_wrr1 && !wrr_found;
  assign winner_idx = !sp0_wrr1 ? sp_idx : (wrr_found ? wrr_idx : req_idx);

`ifdef ARB_TIMEOUT_EN
  logic [15:0] count_reg;
  logic        timeout_err_reg;

  assign timeout_hit = (count_reg == 16'(TIMEOUT_CYCLES - 1)) && !eop[select_reg];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg       <= 16'd0;
      timeout_err_reg <= 1'b0;
    end else begin
      timeout_err_reg <= 1'b0;
      if (state_reg == IDLE) begin
        count_reg <= 16'd0;
      end else if (eop[select_reg]) begin
        count_reg <= 16'd0;
      end else if (timeout_hit) begin
        count_reg       <= 16'd0;
        timeout_err_reg <= 1'b1;
      end else begin
        count_reg <= count_reg + 16'd1;
      end
    end
  end

  assign timeout_err = timeout_err_reg;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign release_now = (state_reg == XFER) && (eop[select_reg] || timeout_hit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      grant_reg       <= '0;
      select_reg      <= 4'd0;
      transfering_reg <= 1'b0;
      rr_ptr_reg      <= 4'(num_of_ports - 1);
    end else if (decide) begin
      state_reg              <= XFER;
      grant_reg              <= '0;
      grant_reg[winner_idx]  <= 1'b1;
      select_reg             <= winner_idx;
      transfering_reg        <= 1'b1;
      rr_ptr_reg             <= winner_idx;
    end else if (release_now) begin
      state_reg       <= IDLE;
      grant_reg       <= '0;
      select_reg      <= 4'd0;
      transfering_reg <= 1'b0;
    end
  end

  // Credits only move on a WRR decision; a reload charges the winner in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < num_of_ports; i++) credit_reg[i] <= 4'd0;
    end else if (decide && sp0_wrr1) begin
      for (int i = 0; i < num_of_ports; i++) begin
        if (reload) begin
          if (4'(i) == winner_idx) credit_reg[i] <= {1'b0, prio_arr[i]};
          else                     credit_reg[i] <= {1'b0, prio_arr[i]} + 4'd1;
        end else if (4'(i) == winner_idx) begin
          credit_reg[i] <= credit_reg[i] - 4'd1;
        end
      end
    end
  end

  assign grant       = grant_reg;
  assign select      = select_reg;
  assign transfering = transfering_reg;

endmodule
